// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions for the load/store unit.
//   mem_size_t : memory access size encoding seen by the OTTER memory.
//   sq_entry_t : one store-queue entry (address, data, size, committed flag).
package cpu_types;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_size_t   size;
        logic        committed;
    } sq_entry_t;

endpackage

// File: rtl/sq_fifo.sv
// Store-queue circular buffer with head (oldest), commit (oldest uncommitted)
// and tail (next free) pointers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_*        write a new uncommitted entry at tail
//   commit              mark the commit-pointer entry committed (ignored if none)
//   pop                 retire the head entry (caller guarantees it is committed)
//   flush               tail <= commit pointer, dropping uncommitted entries
//   head_entry/valid    oldest entry and its occupancy
//   full, empty         occupancy flags
//   entry_valid         per-entry occupancy vector
//   entry_word          per-entry word address (addr[31:2]) for conflict checks
module sq_fifo
    import cpu_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [31:0]             push_addr,
    input  logic [31:0]             push_data,
    input  mem_size_t               push_size,
    input  logic                    commit,
    input  logic                    pop,
    input  logic                    flush,
    output sq_entry_t               head_entry,
    output logic                    head_valid,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH-1:0][29:0]  entry_word
);

    localparam int unsigned PW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty after wrap-around.
    logic [PW:0]                head_q, cmt_q, tail_q;
    logic [PW-1:0]              head_idx, cmt_idx, tail_idx;
    sq_entry_t [DEPTH-1:0]      entries_q;
    logic [DEPTH-1:0]           valid_q;
    logic                       do_commit;
    logic [PW:0]                cmt_next;

    assign head_idx   = head_q[PW-1:0];
    assign cmt_idx    = cmt_q[PW-1:0];
    assign tail_idx   = tail_q[PW-1:0];

    assign do_commit  = commit && (cmt_q != tail_q);
    assign cmt_next   = cmt_q + {{PW{1'b0}}, do_commit};

    assign empty      = (head_q == tail_q);
    assign full       = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
    assign head_entry = entries_q[head_idx];
    assign head_valid = valid_q[head_idx];
    assign entry_valid = valid_q;

    always_comb begin
        entry_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_word[i] = entries_q[i].addr[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            valid_q   <= '0;
            entries_q <= '0;
        end else begin
            if (do_commit) begin
                entries_q[cmt_idx].committed <= 1'b1;
                cmt_q <= cmt_next;
            end
            if (pop) begin
                valid_q[head_idx] <= 1'b0;
                head_q <= head_q + 1'b1;
            end
            // Push after pop: when full, the freed head slot is the tail slot.
            if (push) begin
                entries_q[tail_idx] <= '{addr: push_addr, data: push_data,
                                         size: push_size, committed: 1'b0};
                valid_q[tail_idx]   <= 1'b1;
                tail_q <= tail_q + 1'b1;
            end
            // Same-cycle commit is honoured first, so that entry survives.
            if (flush) begin
                tail_q <= cmt_next;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!entries_q[i].committed &&
                        !(do_commit && (PW'(i) == cmt_idx))) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lsu_store_queue.sv
// Load/store initiator for OTTER memory data port 2.
// Stores wait in an in-order queue until committed by the ROB, then drain to
// memory; loads go straight to memory and return a tagged result one cycle
// later. One memory operation per cycle.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   req_*                    tagged load/store request with valid/ready
//   st_commit                oldest uncommitted store committed
//   flush                    discard uncommitted stores and pending load result
//   MEM_*                    memory port 2 interface
//   ld_valid/ld_tag/ld_data  load result
//   sq_full, sq_empty        store-queue occupancy
module lsu_store_queue
    import cpu_types::*;
#(
    parameter int unsigned SQ_DEPTH = 4,
    parameter int unsigned TAG_W    = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              st_commit,
    input  logic              flush,
    output logic [31:0]       MEM_ADDR2,
    output logic [31:0]       MEM_DIN2,
    output logic              MEM_WRITE2,
    output logic              MEM_READ2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [31:0]       MEM_DOUT2,
    output logic              ld_valid,
    output logic [TAG_W-1:0]  ld_tag,
    output logic [31:0]       ld_data,
    output logic              sq_full,
    output logic              sq_empty
);

    sq_entry_t                     head_entry;
    logic                          head_valid;
    logic [SQ_DEPTH-1:0]           entry_valid;
    logic [SQ_DEPTH-1:0][29:0]     entry_word;
    logic                          head_drainable;
    logic                          conflict;
    logic                          store_acc;
    logic                          load_acc;
    logic                          drain;

    logic [31:0]                   addr_q;
    logic [31:0]                   din_q;
    logic [1:0]                    size_q;
    logic                          sign_q;
    logic                          ld_pend_q;
    logic [TAG_W-1:0]              ld_tag_q;

    sq_fifo #(
        .DEPTH (SQ_DEPTH)
    ) u_sq_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push        (store_acc),
        .push_addr   (req_addr),
        .push_data   (req_data),
        .push_size   (mem_size_t'(req_size)),
        .commit      (st_commit),
        .pop         (drain),
        .flush       (flush),
        .head_entry  (head_entry),
        .head_valid  (head_valid),
        .full        (sq_full),
        .empty       (sq_empty),
        .entry_valid (entry_valid),
        .entry_word  (entry_word)
    );

    assign head_drainable = head_valid && head_entry.committed;

    // Word-granular, deliberately conservative: any queued store to the same
    // word blocks the load, since there is no store-to-load forwarding.
    always_comb begin
        conflict = 1'b0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (entry_valid[i] && (entry_word[i] == req_addr[31:2])) begin
                conflict = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = 1'b0;
        if (!flush) begin
            if (req_is_store) begin
                req_ready = !sq_full;
            end else begin
                // A full queue with a committed head must drain to make progress.
                req_ready = !conflict && !(sq_full && head_drainable);
            end
        end
    end

    assign store_acc = req_valid && req_is_store && req_ready;
    assign load_acc  = req_valid && !req_is_store && req_ready;
    assign drain     = !load_acc && head_drainable;

    always_comb begin
        MEM_READ2  = load_acc;
        MEM_WRITE2 = drain;
        MEM_ADDR2  = addr_q;
        MEM_DIN2   = din_q;
        MEM_SIZE   = size_q;
        MEM_SIGN   = sign_q;
        if (load_acc) begin
            MEM_ADDR2 = req_addr;
            MEM_SIZE  = req_size;
            MEM_SIGN  = req_sign;
        end else if (drain) begin
            MEM_ADDR2 = head_entry.addr;
            MEM_DIN2  = head_entry.data;
            MEM_SIZE  = head_entry.size;
            MEM_SIGN  = 1'b0;
        end
    end

    // Idle cycles replay the last driven address/data/size/sign.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
            din_q  <= '0;
            size_q <= '0;
            sign_q <= 1'b0;
        end else if (load_acc || drain) begin
            addr_q <= MEM_ADDR2;
            din_q  <= MEM_DIN2;
            size_q <= MEM_SIZE;
            sign_q <= MEM_SIGN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_pend_q <= 1'b0;
            ld_tag_q  <= '0;
        end else begin
            ld_pend_q <= load_acc;
            if (load_acc) begin
                ld_tag_q <= req_tag;
            end
        end
    end

    // A flush in the response cycle cancels the in-flight load result.
    assign ld_valid = ld_pend_q && !flush;
    assign ld_tag   = ld_tag_q;
    assign ld_data  = MEM_DOUT2;

endmodule

// File: tb/tb_lsu_store_queue.sv
module tb_lsu_store_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [4:0]  req_tag;
    logic        st_commit;
    logic        flush;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;
    logic        ld_valid;
    logic [4:0]  ld_tag;
    logic [31:0] ld_data;
    logic        sq_full;
    logic        sq_empty;

    int total = 0;
    int bad   = 0;

    lsu_store_queue #(
        .SQ_DEPTH (4),
        .TAG_W    (5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .req_tag      (req_tag),
        .st_commit    (st_commit),
        .flush        (flush),
        .MEM_ADDR2    (MEM_ADDR2),
        .MEM_DIN2     (MEM_DIN2),
        .MEM_WRITE2   (MEM_WRITE2),
        .MEM_READ2    (MEM_READ2),
        .MEM_SIZE     (MEM_SIZE),
        .MEM_SIGN     (MEM_SIGN),
        .MEM_DOUT2    (MEM_DOUT2),
        .ld_valid     (ld_valid),
        .ld_tag       (ld_tag),
        .ld_data      (ld_data),
        .sq_full      (sq_full),
        .sq_empty     (sq_empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_size     = 2'b00;
        req_sign     = 1'b0;
        req_tag      = '0;
        st_commit    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        clr();
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_addr     = a;
        req_data     = d;
        req_size     = 2'b10;
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] t,
                        input logic [1:0] s, input logic sg);
        clr();
        req_valid    = 1'b1;
        req_addr     = a;
        req_tag      = t;
        req_size     = s;
        req_sign     = sg;
    endtask

    initial begin
        clr();
        MEM_DOUT2 = '0;
        RST = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_empty", 32'(sq_empty), 32'd1);
        chk("rst_full", 32'(sq_full), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_ld_tag", 32'(ld_tag), 32'd0);
        chk("rst_read", 32'(MEM_READ2), 32'd0);
        chk("rst_write", 32'(MEM_WRITE2), 32'd0);
        RST = 1'b0;
        tick();

        // Store, commit, drain
        store(32'h100, 32'hDEADBEEF);
        settle();
        chk("st_ready", 32'(req_ready), 32'd1);
        chk("st_nowrite", 32'(MEM_WRITE2), 32'd0);
        tick();
        clr();
        st_commit = 1'b1;
        settle();
        chk("st_notempty", 32'(sq_empty), 32'd0);
        chk("st_commit_nowrite", 32'(MEM_WRITE2), 32'd0);
        tick();
        clr();
        settle();
        chk("drain_write", 32'(MEM_WRITE2), 32'd1);
        chk("drain_addr", MEM_ADDR2, 32'h100);
        chk("drain_din", MEM_DIN2, 32'hDEADBEEF);
        chk("drain_size", 32'(MEM_SIZE), 32'd2);
        chk("drain_sign", 32'(MEM_SIGN), 32'd0);
        tick();
        settle();
        chk("drain_empty", 32'(sq_empty), 32'd1);
        chk("idle_write", 32'(MEM_WRITE2), 32'd0);
        chk("idle_addr_hold", MEM_ADDR2, 32'h100);

        // Load latency
        load(32'h200, 5'd3, 2'b00, 1'b1);
        settle();
        chk("ld_ready", 32'(req_ready), 32'd1);
        chk("ld_read", 32'(MEM_READ2), 32'd1);
        chk("ld_addr", MEM_ADDR2, 32'h200);
        chk("ld_size", 32'(MEM_SIZE), 32'd0);
        chk("ld_sign", 32'(MEM_SIGN), 32'd1);
        chk("ld_notyet", 32'(ld_valid), 32'd0);
        tick();
        clr();
        MEM_DOUT2 = 32'hFFFFFF80;
        settle();
        chk("ld_valid", 32'(ld_valid), 32'd1);
        chk("ld_tag", 32'(ld_tag), 32'd3);
        chk("ld_data", ld_data, 32'hFFFFFF80);
        chk("ld_read_off", 32'(MEM_READ2), 32'd0);
        tick();
        settle();
        chk("ld_valid_off", 32'(ld_valid), 32'd0);

        // Address conflict
        store(32'h104, 32'h11);
        tick();
        load(32'h106, 5'd7, 2'b10, 1'b0);
        settle();
        chk("cf_blocked", 32'(req_ready), 32'd0);
        chk("cf_noread", 32'(MEM_READ2), 32'd0);
        chk("cf_nowrite", 32'(MEM_WRITE2), 32'd0);
        tick();
        st_commit = 1'b1;
        settle();
        chk("cf_blocked_commit", 32'(req_ready), 32'd0);
        tick();
        st_commit = 1'b0;
        settle();
        chk("cf_drain_write", 32'(MEM_WRITE2), 32'd1);
        chk("cf_drain_addr", MEM_ADDR2, 32'h104);
        chk("cf_blocked_drain", 32'(req_ready), 32'd0);
        chk("cf_drain_noread", 32'(MEM_READ2), 32'd0);
        tick();
        settle();
        chk("cf_ready", 32'(req_ready), 32'd1);
        chk("cf_read", 32'(MEM_READ2), 32'd1);
        chk("cf_ld_addr", MEM_ADDR2, 32'h106);
        tick();
        clr();
        MEM_DOUT2 = 32'h1234;
        settle();
        chk("cf_ld_valid", 32'(ld_valid), 32'd1);
        chk("cf_ld_tag", 32'(ld_tag), 32'd7);
        chk("cf_ld_data", ld_data, 32'h1234);
        tick();

        // Full priority
        for (int i = 0; i < 4; i++) begin
            store(32'h400 + 32'(4 * i), 32'(i + 1));
            settle();
            chk("fp_fill_ready", 32'(req_ready), 32'd1);
            tick();
        end
        store(32'h410, 32'h55);
        settle();
        chk("fp_full", 32'(sq_full), 32'd1);
        chk("fp_store_blocked", 32'(req_ready), 32'd0);
        load(32'h300, 5'd1, 2'b10, 1'b0);
        st_commit = 1'b1;
        settle();
        chk("fp_c1_ready", 32'(req_ready), 32'd1);
        chk("fp_c1_read", 32'(MEM_READ2), 32'd1);
        chk("fp_c1_nowrite", 32'(MEM_WRITE2), 32'd0);
        tick();
        req_tag = 5'd2;
        settle();
        chk("fp_c2_ldv", 32'(ld_valid), 32'd1);
        chk("fp_c2_ldtag", 32'(ld_tag), 32'd1);
        chk("fp_c2_full", 32'(sq_full), 32'd1);
        chk("fp_c2_stall", 32'(req_ready), 32'd0);
        chk("fp_c2_write", 32'(MEM_WRITE2), 32'd1);
        chk("fp_c2_noread", 32'(MEM_READ2), 32'd0);
        chk("fp_c2_addr", MEM_ADDR2, 32'h400);
        tick();
        settle();
        chk("fp_c3_ldv", 32'(ld_valid), 32'd0);
        chk("fp_c3_notfull", 32'(sq_full), 32'd0);
        chk("fp_c3_ready", 32'(req_ready), 32'd1);
        chk("fp_c3_read", 32'(MEM_READ2), 32'd1);
        chk("fp_c3_nowrite", 32'(MEM_WRITE2), 32'd0);
        tick();
        tick();
        clr();
        settle();
        chk("fp_d2_write", 32'(MEM_WRITE2), 32'd1);
        chk("fp_d2_addr", MEM_ADDR2, 32'h404);
        chk("fp_d2_din", MEM_DIN2, 32'd2);
        tick();
        settle();
        chk("fp_d3_addr", MEM_ADDR2, 32'h408);
        tick();
        settle();
        chk("fp_d4_write", 32'(MEM_WRITE2), 32'd1);
        chk("fp_d4_addr", MEM_ADDR2, 32'h40C);
        chk("fp_d4_din", MEM_DIN2, 32'd4);
        tick();
        settle();
        chk("fp_empty", 32'(sq_empty), 32'd1);
        chk("fp_idle", 32'(MEM_WRITE2), 32'd0);

        // Flush
        store(32'h500, 32'hA0);
        tick();
        store(32'h504, 32'hA1);
        tick();
        store(32'h508, 32'hA2);
        tick();
        load(32'h600, 5'd9, 2'b10, 1'b0);
        st_commit = 1'b1;
        settle();
        chk("fl_ld_ready", 32'(req_ready), 32'd1);
        chk("fl_ld_read", 32'(MEM_READ2), 32'd1);
        tick();
        clr();
        flush = 1'b1;
        req_is_store = 1'b1;
        settle();
        chk("fl_ld_suppressed", 32'(ld_valid), 32'd0);
        chk("fl_ready_low", 32'(req_ready), 32'd0);
        chk("fl_write", 32'(MEM_WRITE2), 32'd1);
        chk("fl_addr", MEM_ADDR2, 32'h500);
        tick();
        clr();
        settle();
        chk("fl_empty", 32'(sq_empty), 32'd1);
        chk("fl_one_write", 32'(MEM_WRITE2), 32'd0);
        chk("fl_no_ldv", 32'(ld_valid), 32'd0);
        tick();

        // Asynchronous reset mid-drain
        store(32'h700, 32'hB0);
        tick();
        store(32'h704, 32'hB1);
        st_commit = 1'b1;
        tick();
        clr();
        st_commit = 1'b1;
        settle();
        chk("ar_drain_write", 32'(MEM_WRITE2), 32'd1);
        chk("ar_drain_addr", MEM_ADDR2, 32'h700);
        clr();
        RST = 1'b1;
        #1;
        chk("ar_empty", 32'(sq_empty), 32'd1);
        chk("ar_write", 32'(MEM_WRITE2), 32'd0);
        chk("ar_ldv", 32'(ld_valid), 32'd0);
        chk("ar_full", 32'(sq_full), 32'd0);
        tick();
        RST = 1'b0;
        tick();
        settle();
        chk("ar_after_empty", 32'(sq_empty), 32'd1);
        chk("ar_after_write", 32'(MEM_WRITE2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
